// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left/right, rotate left/right,
// parallel load and clear, with a serial-shift counter that pulses
// word_done when WIDTH serial bits have been shifted through.
module univ_shift_reg #(
   parameter int                 WIDTH   = 8,
   parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [2:0]                   mode,
   input  logic                         sin_r,
   input  logic                         sin_l,
   input  logic [WIDTH-1:0]             pdata,
   output logic [WIDTH-1:0]             q,
   output logic                         sout_r,
   output logic                         sout_l,
   output logic                         word_done,
   output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'b000,
      MODE_SHR   = 3'b001,
      MODE_SHL   = 3'b010,
      MODE_ROTR  = 3'b011,
      MODE_ROTL  = 3'b100,
      MODE_LOAD  = 3'b101,
      MODE_CLEAR = 3'b110,
      MODE_RSVD  = 3'b111
   } mode_t;

   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             word_done_q, word_done_d;
   logic             is_shift;
   mode_t            mode_e;

   assign mode_e = mode_t'(mode);

   // Next-state logic for the register, the serial-shift counter and the word pulse.
   always_comb begin
      // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
      q_d         = q_q;
      bit_cnt_d   = bit_cnt_q;
      word_done_d = 1'b0;
      is_shift    = 1'b0;

      if (en) begin
         case (mode_e)
            MODE_SHR: begin
               q_d      = {sin_r, q_q[WIDTH-1:1]};
               is_shift = 1'b1;
            end
            MODE_SHL: begin
               q_d      = {q_q[WIDTH-2:0], sin_l};
               is_shift = 1'b1;
            end
            MODE_ROTR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            MODE_ROTL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_LOAD: begin
               q_d       = pdata;
               bit_cnt_d = '0;
            end
            MODE_CLEAR: begin
               q_d       = '0;
               bit_cnt_d = '0;
            end
            default: ; // hold and reserved keep everything as is
         endcase

         // Only serial shifts advance the count; the last bit of a word wraps it.
         if (is_shift) begin
            if (bit_cnt_q == CNT_LAST) begin
               bit_cnt_d   = '0;
               word_done_d = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         q_q         <= RST_VAL;
         bit_cnt_q   <= '0;
         word_done_q <= 1'b0;
      end else begin
         q_q         <= q_d;
         bit_cnt_q   <= bit_cnt_d;
         word_done_q <= word_done_d;
      end
   end

   assign q         = q_q;
   assign sout_r    = q_q[0];
   assign sout_l    = q_q[WIDTH-1];
   assign word_done = word_done_q;
   assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed testbench for univ_shift_reg (WIDTH=8, RST_VAL=0).
module tb_univ_shift_reg;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [2:0]   mode;
   logic         sin_r;
   logic         sin_l;
   logic [W-1:0] pdata;
   logic [W-1:0] q;
   logic         sout_r;
   logic         sout_l;
   logic         word_done;
   logic [3:0]   bit_cnt;

   int checks   = 0;
   int failures = 0;

   univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .sin_r     (sin_r),
      .sin_l     (sin_l),
      .pdata     (pdata),
      .q         (q),
      .sout_r    (sout_r),
      .sout_l    (sout_l),
      .word_done (word_done),
      .bit_cnt   (bit_cnt)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; mode = 3'b101; pdata = 8'hAA; sin_r = 1'b1; sin_l = 1'b1;
      tick();
      tick();
      checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=%h", q, 8'h00); end
      checks++; if (bit_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bit_cnt); end
      checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL reset_wd got=%b exp=0", word_done); end
      checks++; if (sout_r !== 1'b0 || sout_l !== 1'b0) begin failures++; $display("FAIL reset_sout got=%b%b exp=00", sout_l, sout_r); end
      rst = 1'b0; en = 1'b0; mode = 3'b000;
      tick();
   endtask

   task automatic test_serial_fill();
      logic [7:0] bits;
      bits = 8'b0100_1101; // sin_r sequence 1,0,1,1,0,0,1,0 taken from bit 0 upward
      en = 1'b1; mode = 3'b001;
      for (int i = 0; i < 8; i++) begin
         sin_r = bits[i];
         tick();
         checks++;
         if (word_done !== (i == 7)) begin
            failures++; $display("FAIL fill_wd edge=%0d got=%b exp=%b", i, word_done, (i == 7));
         end
      end
      checks++; if (q !== 8'h4D) begin failures++; $display("FAIL fill_q got=%h exp=4d", q); end
      checks++; if (bit_cnt !== 4'd0) begin failures++; $display("FAIL fill_cnt got=%0d exp=0", bit_cnt); end
      checks++; if (sout_r !== 1'b1 || sout_l !== 1'b0) begin failures++; $display("FAIL fill_sout got=%b%b exp=01", sout_l, sout_r); end
      mode = 3'b000;
      tick();
      checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL fill_wd_after got=%b exp=0", word_done); end
   endtask

   task automatic test_rotate();
      logic [7:0] exp_q [4];
      logic [2:0] modes [4];
      exp_q = '{8'h81, 8'h03, 8'h81, 8'hC0};
      modes = '{3'b101, 3'b100, 3'b011, 3'b011};
      en = 1'b1; pdata = 8'h81;
      for (int i = 0; i < 4; i++) begin
         mode = modes[i];
         tick();
         checks++; if (q !== exp_q[i]) begin failures++; $display("FAIL rot_q step=%0d got=%h exp=%h", i, q, exp_q[i]); end
         checks++; if (bit_cnt !== 4'd0 || word_done !== 1'b0) begin
            failures++; $display("FAIL rot_cnt_wd step=%0d got cnt=%0d wd=%b exp cnt=0 wd=0", i, bit_cnt, word_done);
         end
      end
   endtask

   task automatic test_load_at_boundary();
      en = 1'b1; mode = 3'b010; sin_l = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      checks++; if (bit_cnt !== 4'd7) begin failures++; $display("FAIL bnd_cnt7 got=%0d exp=7", bit_cnt); end
      mode = 3'b101; pdata = 8'h3C;
      tick();
      checks++; if (q !== 8'h3C) begin failures++; $display("FAIL bnd_q got=%h exp=3c", q); end
      checks++; if (bit_cnt !== 4'd0) begin failures++; $display("FAIL bnd_cnt got=%0d exp=0", bit_cnt); end
      checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL bnd_wd got=%b exp=0", word_done); end
      mode = 3'b000;
      tick();
      checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL bnd_wd_after got=%b exp=0", word_done); end
   endtask

   task automatic test_enable_gating();
      logic [7:0] exp_q [5];
      exp_q = '{8'hF3, 8'hF9, 8'hFC, 8'hFE, 8'hFF};
      en = 1'b1; mode = 3'b001; sin_r = 1'b1; // q starts at 3C, count 0
      for (int i = 0; i < 3; i++) tick();
      checks++; if (q !== 8'hE7 || bit_cnt !== 4'd3) begin
         failures++; $display("FAIL gate_pre got q=%h cnt=%0d exp q=e7 cnt=3", q, bit_cnt);
      end
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (q !== 8'hE7 || bit_cnt !== 4'd3 || word_done !== 1'b0) begin
            failures++; $display("FAIL gate_hold edge=%0d got q=%h cnt=%0d wd=%b exp q=e7 cnt=3 wd=0", i, q, bit_cnt, word_done);
         end
      end
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (q !== exp_q[i] || word_done !== (i == 4)) begin
            failures++; $display("FAIL gate_run edge=%0d got q=%h wd=%b exp q=%h wd=%b", i, q, word_done, exp_q[i], (i == 4));
         end
      end
      checks++; if (bit_cnt !== 4'd0) begin failures++; $display("FAIL gate_cnt got=%0d exp=0", bit_cnt); end
   endtask

   task automatic test_async_reset();
      en = 1'b1; mode = 3'b101; pdata = 8'hFF;
      tick();
      mode = 3'b001; sin_r = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (q !== 8'h0F || bit_cnt !== 4'd4) begin
         failures++; $display("FAIL areset_pre got q=%h cnt=%0d exp q=0f cnt=4", q, bit_cnt);
      end
      #3 rst = 1'b1;
      #1;
      checks++; if (q !== 8'h00 || bit_cnt !== 4'd0 || word_done !== 1'b0) begin
         failures++; $display("FAIL areset_async got q=%h cnt=%0d wd=%b exp q=00 cnt=0 wd=0", q, bit_cnt, word_done);
      end
      tick(); // enabled shift while in reset must be ignored
      checks++; if (q !== 8'h00 || bit_cnt !== 4'd0) begin
         failures++; $display("FAIL areset_held got q=%h cnt=%0d exp q=00 cnt=0", q, bit_cnt);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL areset_nowd edge=%0d got=%b exp=0", i, word_done); end
      end
      checks++; if (bit_cnt !== 4'd4) begin failures++; $display("FAIL areset_cnt got=%0d exp=4", bit_cnt); end
   endtask

   task automatic test_mixed_direction();
      en = 1'b1; mode = 3'b110;
      tick();
      checks++; if (q !== 8'h00 || bit_cnt !== 4'd0) begin
         failures++; $display("FAIL mix_clear got q=%h cnt=%0d exp q=00 cnt=0", q, bit_cnt);
      end
      sin_r = 1'b1; sin_l = 1'b1;
      for (int i = 0; i < 8; i++) begin
         mode = (i < 4) ? 3'b001 : 3'b010;
         tick();
         checks++; if (word_done !== (i == 7)) begin
            failures++; $display("FAIL mix_wd edge=%0d got=%b exp=%b", i, word_done, (i == 7));
         end
         if (i == 3) begin
            checks++; if (q !== 8'hF0) begin failures++; $display("FAIL mix_mid_q got=%h exp=f0", q); end
         end
      end
      checks++; if (q !== 8'h0F || bit_cnt !== 4'd0) begin
         failures++; $display("FAIL mix_final got q=%h cnt=%0d exp q=0f cnt=0", q, bit_cnt);
      end
   endtask

   task automatic test_clear_and_reserved();
      en = 1'b1; mode = 3'b101; pdata = 8'hA5;
      tick();
      mode = 3'b010; sin_l = 1'b0;
      tick();
      checks++; if (q !== 8'h4A || bit_cnt !== 4'd1) begin
         failures++; $display("FAIL rsv_pre got q=%h cnt=%0d exp q=4a cnt=1", q, bit_cnt);
      end
      mode = 3'b111;
      tick();
      checks++; if (q !== 8'h4A || bit_cnt !== 4'd1 || word_done !== 1'b0) begin
         failures++; $display("FAIL rsv_hold got q=%h cnt=%0d wd=%b exp q=4a cnt=1 wd=0", q, bit_cnt, word_done);
      end
      mode = 3'b000;
      tick();
      checks++; if (q !== 8'h4A || bit_cnt !== 4'd1) begin
         failures++; $display("FAIL hold got q=%h cnt=%0d exp q=4a cnt=1", q, bit_cnt);
      end
      mode = 3'b011;
      tick();
      checks++; if (q !== 8'h25 || bit_cnt !== 4'd1) begin
         failures++; $display("FAIL rsv_rotr got q=%h cnt=%0d exp q=25 cnt=1", q, bit_cnt);
      end
      mode = 3'b010; sin_l = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      checks++; if (bit_cnt !== 4'd7) begin failures++; $display("FAIL clr_cnt7 got=%0d exp=7", bit_cnt); end
      mode = 3'b110;
      tick();
      checks++; if (q !== 8'h00 || bit_cnt !== 4'd0 || word_done !== 1'b0) begin
         failures++; $display("FAIL clr_bnd got q=%h cnt=%0d wd=%b exp q=00 cnt=0 wd=0", q, bit_cnt, word_done);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 3'b000; sin_r = 1'b0; sin_l = 1'b0; pdata = 8'h00;
      test_reset();
      test_serial_fill();
      test_rotate();
      test_load_at_boundary();
      test_enable_gating();
      test_async_reset();
      test_mixed_direction();
      test_clear_and_reserved();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
